mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Instruction sequencer for the MCxxxx core: owns the program counter, conditional-execution flag, once-only (`@`) line mask and sleep timer. It sits between the program ROM and the instruction decoder. Each cycle it presents `pc`, reads back the fetched word and the decoder's control flags, and decides whether the current line commits. It also decides where execution goes next.

## Interface
Parameters:
- `PROG_DEPTH`, 16: maximum program lines.
- `AW`, `$clog2(PROG_DEPTH)`: PC width.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high; one clock; all state cleared on the edge it is sampled.
- `start` in 1: begin execution at line 0; honoured only in IDLE.
- `tick` in 1: one-cycle game time-unit pulse.
- `prog_len` in AW+1: number of valid lines, 0..PROG_DEPTH.
- `instr` in 31: ROM word at `pc`, combinational read. Bits [30:29] are the prefix: 00 none, 01 `+`, 10 `-`, 11 `@`.
- `is_slp`, `is_jmp`, `is_cond` in 1 each: decoder flags for `instr`.
- `instr_cond` in 1: test result for the current line; 1 means true.
- `slp_val` in 11: signed sleep operand, range -999..999.
- `jmp_tgt` in AW: absolute jump line.
- `pc` out AW: current line address.
- `commit` out 1: combinational; the current line executes this cycle and gates decoder `wr_en`.
- `flag` out 2: 00 NONE, 01 PLUS, 10 MINUS.
- `sleeping` out 1: high in SLEEP.

## Operation
States are IDLE, RUN and SLEEP.

Enable rule in RUN:
- Prefix none: enabled.
- Prefix `+`: enabled only if `flag`=PLUS.
- Prefix `-`: enabled only if `flag`=MINUS.
- Prefix `@`: enabled only if `once_done[pc]`=0.
- `commit` = (state==RUN) && enabled.

Next-line rule: `nxt` = (pc+1 == prog_len) ? 0 : pc+1.

IDLE:
- `start` && `prog_len`≠0 → RUN, pc=0.
- `start` with `prog_len`=0 is ignored.

RUN, one line per clock:
- Disabled line: pc←`nxt`; no other state change.
- Enabled line, `@` prefix: set `once_done[pc]`.
- Enabled line, `is_cond`: flag←`instr_cond` ? PLUS : MINUS.
- Enabled line, `is_jmp`: pc←`jmp_tgt`, or 0 if `jmp_tgt` ≥ `prog_len`.
- Enabled line, `is_slp` with `slp_val`>0: cnt←`slp_val`, pc←`nxt`, go to SLEEP.
- Enabled line, `is_slp` with `slp_val`≤0: treated as no-op; pc←`nxt`.
- Any other enabled line: pc←`nxt`.

SLEEP:
- `tick` decrements cnt.
- `tick` when cnt==1 → RUN on the next cycle.
- No `tick` → hold.
- `commit` stays 0 throughout.
- `start` is ignored.

Arithmetic and reset:
- cnt is 10-bit unsigned, loaded from the positive `slp_val`.
- pc increment wraps via the `prog_len` compare, never via overflow.
- Reset values: state IDLE, pc 0, `flag` NONE, `once_done` all 0, cnt 0, `commit` 0, `sleeping` 0.
- Reset mid-SLEEP or mid-RUN aborts immediately and yields those same values.

## Timing
- Throughput: 1 line/cycle in RUN; pc updates on the clock edge after the line is presented.
- `commit` is valid in the same cycle as `instr`; no registered latency.
- RUN→SLEEP takes 1 edge.
- SLEEP→RUN happens on the edge that samples the final `tick`. The next line executes the following cycle.
- `sleep N` with ticks on every cycle gives `sleeping` high for exactly N cycles.
- `tick` arriving in the same cycle the `slp` line commits is not counted.
- `flag` update and pc redirect take effect on the same edge. A conditional line immediately after a test uses the new flag.
- `reset` has priority over every other input.

## Structure
- Package `mc_pkg` holds:
  - prefix encodings `PFX_NONE/PLUS/MINUS/ONCE`;
  - flag encodings `FLAG_NONE/PLUS/MINUS`;
  - state enum `SEQ_IDLE/RUN/SLEEP`;
  - the 11-bit value width constant, shared with the decoder and ALU.
- One sub-module, `sleep_timer`: load, `tick` decrement, `done` pulse when cnt hits 1 with `tick`.

## Test plan
- **Straight-line wrap:** `prog_len`=3, no flags, `start` → pc 0,1,2,0,1 on consecutive cycles; `commit`=1 each cycle.
- **Conditional:** line 0 test with `instr_cond`=1; line 1 `+`, line 2 `-` → `flag`=PLUS after line 0; `commit` 1 on line 1 and 0 on line 2; `instr_cond`=0 reverses both.
- **Once:** line 0 prefix `@`, `prog_len`=2 → `commit` 1 on first pass at pc 0 and 0 on every later pass.
- **Sleep:** `slp_val`=3, `tick` every 2nd cycle → `sleeping` high until the 3rd tick, then resumes at `nxt`. `slp_val`=0 and -5 → no SLEEP entry.
- **Jump:** `jmp_tgt`=5 with `prog_len`=8 → pc=5 next cycle; `jmp_tgt`=9 → pc=0.
- **Reset:** `reset` asserted mid-SLEEP with cnt=2, `flag`=MINUS, `once_done`≠0 → next cycle IDLE, pc 0, `flag` NONE, mask clear, `sleeping` 0; `start` with `prog_len`=0 → stays IDLE.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the MCxxxx core.
//   - instruction prefix encodings (instr[30:29])
//   - conditional-execution flag encodings
//   - sequencer state enum
//   - VAL_W: width of signed operand values, shared with decoder and ALU
//   - CNT_W: width of the unsigned sleep counter
package mc_pkg;

  localparam int VAL_W = 11;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    PFX_NONE  = 2'b00,
    PFX_PLUS  = 2'b01,
    PFX_MINUS = 2'b10,
    PFX_ONCE  = 2'b11
  } prefix_t;

  typedef enum logic [1:0] {
    FLAG_NONE  = 2'b00,
    FLAG_PLUS  = 2'b01,
    FLAG_MINUS = 2'b10
  } flag_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_RUN   = 2'b01,
    SEQ_SLEEP = 2'b10
  } seq_state_t;

  // Strictly positive test on a two's-complement operand.
  function automatic logic is_positive(input logic [VAL_W-1:0] v);
    return !v[VAL_W-1] && (v != '0);
  endfunction

endpackage

// File: rtl/sleep_timer.sv
// sleep_timer: down-counter for the sleep instruction.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   load       : load load_val (has priority over tick)
//   load_val   : sleep length in time units (>0)
//   tick       : one-cycle time-unit pulse
//   active     : counting enabled (sequencer is in SLEEP)
//   done       : pulses when the final tick is sampled (cnt==1 with tick)
module sleep_timer
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             active,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  // load wins over tick so a tick coinciding with the sleep line is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (active && tick && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = active && tick && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: instruction sequencer for the MCxxxx core.
// Owns pc, the +/- condition flag, the once-only line mask and sleep timer.
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   start           : begin execution at line 0 (IDLE only)
//   tick            : game time-unit pulse (drives the sleep timer)
//   prog_len        : number of valid program lines (0..PROG_DEPTH)
//   instr           : ROM word at pc; [30:29] is the prefix
//   is_slp/is_jmp/is_cond, instr_cond, slp_val, jmp_tgt : decoder inputs
//   pc              : current line address
//   commit          : current line executes this cycle (combinational)
//   flag            : condition flag (NONE/PLUS/MINUS)
//   sleeping        : high while in SLEEP
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic [AW:0]      prog_len,
  input  logic [30:0]      instr,
  input  logic             is_slp,
  input  logic             is_jmp,
  input  logic             is_cond,
  input  logic             instr_cond,
  input  logic [VAL_W-1:0] slp_val,
  input  logic [AW-1:0]    jmp_tgt,
  output logic [AW-1:0]    pc,
  output logic             commit,
  output logic [1:0]       flag,
  output logic             sleeping
);

  seq_state_t            state_reg, state_next;
  logic [AW-1:0]         pc_reg, pc_next;
  flag_t                 flag_reg, flag_next;
  logic [PROG_DEPTH-1:0] once_done;
  logic                  once_set;
  logic                  timer_load;
  logic                  timer_done;
  logic                  enabled;
  prefix_t               pfx;
  logic [AW:0]           pc_plus;
  logic [AW-1:0]         nxt;
  logic                  unused_instr;

  assign unused_instr = ^instr[28:0];
  assign pfx = prefix_t'(instr[30:29]);

  // Increment is done one bit wider so the wrap comes from the prog_len
  // compare and never from overflow of pc itself.
  assign pc_plus = (AW+1)'(pc_reg) + 1'b1;
  assign nxt     = (pc_plus == prog_len) ? '0 : pc_plus[AW-1:0];

  always_comb begin
    enabled = 1'b0;
    unique case (pfx)
      PFX_NONE:  enabled = 1'b1;
      PFX_PLUS:  enabled = (flag_reg == FLAG_PLUS);
      PFX_MINUS: enabled = (flag_reg == FLAG_MINUS);
      PFX_ONCE:  enabled = !once_done[pc_reg];
      default:   enabled = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flag_next  = flag_reg;
    timer_load = 1'b0;
    commit     = 1'b0;
    once_set   = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (start && (prog_len != '0)) begin
          state_next = SEQ_RUN;
          pc_next    = '0;
        end
      end
      SEQ_RUN: begin
        commit  = enabled;
        pc_next = nxt;
        if (enabled) begin
          once_set = (pfx == PFX_ONCE);
          if (is_cond) begin
            flag_next = instr_cond ? FLAG_PLUS : FLAG_MINUS;
          end
          if (is_slp && is_positive(slp_val)) begin
            timer_load = 1'b1;
            state_next = SEQ_SLEEP;
          end
          if (is_jmp) begin
            pc_next = ((AW+1)'(jmp_tgt) >= prog_len) ? '0 : jmp_tgt;
          end
        end
      end
      SEQ_SLEEP: begin
        if (timer_done) begin
          state_next = SEQ_RUN;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEQ_IDLE;
      pc_reg    <= '0;
      flag_reg  <= FLAG_NONE;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flag_reg  <= flag_next;
    end
  end

  // One sticky bit per program line, set the first time an @ line commits.
  genvar gi;
  generate
    for (gi = 0; gi < PROG_DEPTH; gi++) begin : g_once
      logic done_bit_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          done_bit_reg <= 1'b0;
        end else if (once_set && (pc_reg == AW'(gi))) begin
          done_bit_reg <= 1'b1;
        end
      end
      assign once_done[gi] = done_bit_reg;
    end
  endgenerate

  sleep_timer u_sleep_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (slp_val[CNT_W-1:0]),
    .tick     (tick),
    .active   (state_reg == SEQ_SLEEP),
    .done     (timer_done)
  );

  assign pc       = pc_reg;
  assign flag     = flag_reg;
  assign sleeping = (state_reg == SEQ_SLEEP);

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer. A small behavioural ROM answers pc with the
// per-line decoder fields; each scenario pushes per-cycle stimulus with the
// expected {pc, commit, flag, sleeping} into a scoreboard queue and then
// pops and compares one entry per clock.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, tick;
  logic [4:0]  prog_len;
  logic [30:0] instr;
  logic        is_slp, is_jmp, is_cond, instr_cond;
  logic [10:0] slp_val;
  logic [3:0]  jmp_tgt;
  logic [3:0]  pc;
  logic        commit;
  logic [1:0]  flag;
  logic        sleeping;

  logic [1:0]  rom_pfx  [16];
  logic        rom_slp  [16];
  logic        rom_jmp  [16];
  logic        rom_cnd  [16];
  logic        rom_cval [16];
  logic [10:0] rom_sval [16];
  logic [3:0]  rom_jtgt [16];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       st;
    logic       tk;
    logic [7:0] exp;
  } stim_t;

  stim_t sb[$];

  mc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .prog_len   (prog_len),
    .instr      (instr),
    .is_slp     (is_slp),
    .is_jmp     (is_jmp),
    .is_cond    (is_cond),
    .instr_cond (instr_cond),
    .slp_val    (slp_val),
    .jmp_tgt    (jmp_tgt),
    .pc         (pc),
    .commit     (commit),
    .flag       (flag),
    .sleeping   (sleeping)
  );

  always #5 clk = ~clk;

  assign instr      = {rom_pfx[pc], 29'd0};
  assign is_slp     = rom_slp[pc];
  assign is_jmp     = rom_jmp[pc];
  assign is_cond    = rom_cnd[pc];
  assign instr_cond = rom_cval[pc];
  assign slp_val    = rom_sval[pc];
  assign jmp_tgt    = rom_jtgt[pc];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) begin
      rom_pfx[i] = 2'b00; rom_slp[i] = 1'b0; rom_jmp[i] = 1'b0;
      rom_cnd[i] = 1'b0;  rom_cval[i] = 1'b0; rom_sval[i] = 11'd0;
      rom_jtgt[i] = 4'd0;
    end
  endtask

  task automatic set_line(input int i, input logic [1:0] pfx, input logic slp,
                          input logic jmp, input logic cnd, input logic cv,
                          input logic [10:0] sv, input logic [3:0] jt);
    rom_pfx[i] = pfx; rom_slp[i] = slp; rom_jmp[i] = jmp;
    rom_cnd[i] = cnd; rom_cval[i] = cv; rom_sval[i] = sv; rom_jtgt[i] = jt;
  endtask

  task automatic push(input logic rst, input logic st, input logic tk,
                      input logic [3:0] p, input logic c, input logic [1:0] f,
                      input logic s);
    stim_t e;
    e.rst = rst; e.st = st; e.tk = tk; e.exp = {p, c, f, s};
    sb.push_back(e);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input stim_t e);
    reset = e.rst; start = e.st; tick = e.tk;
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {pc, commit, flag, sleeping};
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd3;
    do_reset();
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 1, 4'd0, 0, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("reset cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL reset cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_wrap();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd3;
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd1, 1, 2'd0, 0);
    push(0, 0, 0, 4'd2, 1, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 1, 0, 4'd1, 1, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("wrap cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL wrap cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_cond(input logic cv);
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd3;
    set_line(0, 2'b00, 0, 0, 1, cv, 11'd0, 4'd0);
    set_line(1, 2'b01, 0, 0, 0, 0, 11'd0, 4'd0);
    set_line(2, 2'b10, 0, 0, 0, 0, 11'd0, 4'd0);
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    if (cv) begin
      push(0, 0, 0, 4'd1, 1, 2'd1, 0);
      push(0, 0, 0, 4'd2, 0, 2'd1, 0);
      push(0, 0, 0, 4'd0, 1, 2'd1, 0);
      push(0, 0, 0, 4'd1, 1, 2'd1, 0);
    end else begin
      push(0, 0, 0, 4'd1, 0, 2'd2, 0);
      push(0, 0, 0, 4'd2, 1, 2'd2, 0);
      push(0, 0, 0, 4'd0, 1, 2'd2, 0);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("cond%0b cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cv, cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL cond%0b cyc %0d got %h required %h", cv, cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_once();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd2;
    set_line(0, 2'b11, 0, 0, 0, 0, 11'd0, 4'd0);
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd1, 1, 2'd0, 0);
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd1, 1, 2'd0, 0);
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("once cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL once cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_sleep();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd3;
    set_line(0, 2'b00, 1, 0, 0, 0, 11'd3, 4'd0);
    do_reset();
    // tick on odd cycles; the tick at cyc 1 coincides with the sleep line
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 1, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd1, 0, 2'd0, 1);
    push(0, 0, 1, 4'd1, 0, 2'd0, 1);
    push(0, 1, 0, 4'd1, 0, 2'd0, 1);
    push(0, 0, 1, 4'd1, 0, 2'd0, 1);
    push(0, 0, 0, 4'd1, 0, 2'd0, 1);
    push(0, 0, 1, 4'd1, 0, 2'd0, 1);
    push(0, 0, 0, 4'd1, 1, 2'd0, 0);
    push(0, 0, 0, 4'd2, 1, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("sleep cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL sleep cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_sleep_nonpos();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd2;
    set_line(0, 2'b00, 1, 0, 0, 0, 11'd0, 4'd0);
    set_line(1, 2'b00, 1, 0, 0, 0, 11'h7FB, 4'd0);
    do_reset();
    push(0, 1, 1, 4'd0, 0, 2'd0, 0);
    push(0, 0, 1, 4'd0, 1, 2'd0, 0);
    push(0, 0, 1, 4'd1, 1, 2'd0, 0);
    push(0, 0, 1, 4'd0, 1, 2'd0, 0);
    push(0, 0, 1, 4'd1, 1, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("sleep_nonpos cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL sleep_nonpos cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_jump();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd8;
    set_line(0, 2'b00, 0, 1, 0, 0, 11'd0, 4'd5);
    set_line(5, 2'b00, 0, 1, 0, 0, 11'd0, 4'd9);
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd5, 1, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd5, 1, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("jump cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL jump cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_reset_mid_sleep();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd4;
    set_line(0, 2'b11, 0, 0, 1, 0, 11'd0, 4'd0);
    set_line(1, 2'b00, 1, 0, 0, 0, 11'd5, 4'd0);
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    push(0, 0, 0, 4'd1, 1, 2'd2, 0);
    push(0, 0, 1, 4'd2, 0, 2'd2, 1);
    push(0, 1, 1, 4'd2, 0, 2'd2, 1);
    push(0, 0, 1, 4'd2, 0, 2'd2, 1);
    push(1, 0, 0, 4'd2, 0, 2'd2, 1);
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 1, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("reset_mid_sleep cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL reset_mid_sleep cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  task automatic test_empty_program();
    stim_t e;
    int cyc = 0;
    clear_rom();
    prog_len = 5'd0;
    do_reset();
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    push(0, 1, 0, 4'd0, 0, 2'd0, 0);
    push(0, 0, 0, 4'd0, 0, 2'd0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); drive(e); checks++;
      $display("empty cyc %0d pc=%0d commit=%0b flag=%0d sleeping=%0b", cyc, pc, commit, flag, sleeping);
      if (obs() !== e.exp) begin
        errors++;
        $display("FAIL empty cyc %0d got %h required %h", cyc, obs(), e.exp);
      end
      advance(); cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; prog_len = 5'd0;
    clear_rom();
    advance();
    test_reset();
    test_wrap();
    test_cond(1'b1);
    test_cond(1'b0);
    test_once();
    test_sleep();
    test_sleep_nonpos();
    test_jump();
    test_reset_mid_sleep();
    test_empty_program();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
